// File: rtl/multicycle_datapath.sv
// Purpose: multi-cycle MIPS-subset core; one shared ALU and one external memory port.
// Latency: beq/j 3, R-type/addi/sw 4, lw 5 cycles at zero wait states; +1 per mem_ready-low cycle.
// Backpressure: mem_req/we/addr/wdata held stable until mem_ready is sampled high; HALT is terminal.
// Ports: clock/reset (async active-high); mem_* request/ready memory port (instruction + data);
//        dbg_ra/dbg_rd combinational register peek; pc, instr, retire pulse, sticky halted.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        dbg_ra,
  output logic [31:0]       dbg_rd,
  output logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              retire,
  output logic              halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_out_q, mdr_q;
  logic        mem_req_q, mem_we_q, halted_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [31:0] rf_q [32];

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm;
  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign simm  = {{16{ir_q[15]}}, ir_q[15:0]};

  logic legal;
  always_comb begin
    case (op)
      OP_RTYPE: legal = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                        (funct == F_OR)  || (funct == F_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  // Shared ALU: operand selection depends on the current state.
  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_fn;
  always_comb begin
    alu_a  = a_q;
    alu_b  = simm;
    alu_fn = ALU_ADD;
    case (state_q)
      S_FETCH:  begin alu_a = pc_q; alu_b = 32'd4; end
      S_DECODE: begin alu_a = pc_q; alu_b = {simm[29:0], 2'b00}; end
      S_EXEC: begin
        alu_b = b_q;
        case (funct)
          F_SUB:   alu_fn = ALU_SUB;
          F_AND:   alu_fn = ALU_AND;
          F_OR:    alu_fn = ALU_OR;
          F_SLT:   alu_fn = ALU_SLT;
          default: alu_fn = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_fn)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  // retire is decoded from the state so that a store retires in the very
  // cycle its write is accepted, however many wait states preceded it.
  logic retire_c;
  always_comb begin
    case (state_q)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire_c = 1'b1;
      S_MEMWR: retire_c = mem_ready;
      default: retire_c = 1'b0;
    endcase
  end

  // Next fetch address after a retiring state (pc already holds pc+4).
  logic [31:0] npc;
  always_comb begin
    case (state_q)
      S_BRANCH: npc = (a_q == b_q) ? alu_out_q : pc_q;
      S_JUMP:   npc = {pc_q[31:28], ir_q[25:0], 2'b00};
      default:  npc = pc_q;
    endcase
  end

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  always_comb begin
    rf_we = 1'b0;
    rf_wa = rt;
    rf_wd = alu_out_q;
    case (state_q)
      S_MEMWB:  begin rf_we = 1'b1; rf_wd = mdr_q; end
      S_ADDIWB: rf_we = 1'b1;
      S_ALUWB:  begin rf_we = 1'b1; rf_wa = rd; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_out_q   <= '0;
      mdr_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (rf_we && (rf_wa != 5'd0)) rf_q[rf_wa] <= rf_wd;
      case (state_q)
        S_FETCH: begin
          // Only taken straight after reset: the request is registered, so
          // the first fetch is issued one cycle late.
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
          end else if (mem_ready) begin
            ir_q      <= mem_rdata;
            pc_q      <= alu_y;
            mem_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q       <= rf_q[rs];
          b_q       <= rf_q[rt];
          alu_out_q <= alu_y;
          if (!legal) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            case (op)
              OP_LW, OP_SW: state_q <= S_MEMADR;
              OP_RTYPE:     state_q <= S_EXEC;
              OP_ADDI:      state_q <= S_ADDIEX;
              OP_BEQ:       state_q <= S_BRANCH;
              default:      state_q <= S_JUMP;
            endcase
          end
        end
        S_MEMADR: begin
          alu_out_q <= alu_y;
          if (alu_y[1:0] != 2'b00) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= (op == OP_SW);
            mem_addr_q  <= alu_y;
            mem_wdata_q <= b_q;
            state_q     <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
          end
        end
        S_MEMRD: begin
          if (mem_ready) begin
            mdr_q     <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= S_MEMWB;
          end
        end
        S_EXEC: begin
          alu_out_q <= alu_y;
          state_q   <= S_ALUWB;
        end
        S_ADDIEX: begin
          alu_out_q <= alu_y;
          state_q   <= S_ADDIWB;
        end
        default: ;
      endcase
      // Every retiring state launches the next fetch directly.
      if (retire_c) begin
        pc_q       <= npc;
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= npc;
        state_q    <= S_FETCH;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q[ADDR_W-1:0];
  assign mem_wdata = mem_wdata_q;
  assign dbg_rd    = (dbg_ra == 5'd0) ? 32'd0 : rf_q[dbg_ra];
  assign pc        = pc_q;
  assign instr     = ir_q;
  assign retire    = retire_c;
  assign halted    = halted_q;

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle MIPS-subset core: a state machine sequences fetch, decode, execute, memory and writeback over several clock cycles and shares one ALU and one external memory port. It supersedes the single-cycle datapath and adds a request/ready memory handshake with wait states, branch/jump support, per-instruction retire signalling and an illegal-instruction halt. Instruction and data memory sit outside the block on the shared memory port.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)
- ADDR_W, 32, width of mem_addr; byte address bits [ADDR_W-1:0] of the 32-bit address are driven
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  ADDR_W  byte address, always word aligned
- mem_wdata  out  32  store data; valid while mem_req=1 and mem_we=1
- mem_rdata  in  32  read data; sampled on the edge where mem_ready=1
- mem_ready  in  1  completes the current transaction; ignored when mem_req=0
- dbg_ra  in  5  debug register-file read address
- dbg_rd  out  32  combinational contents of register dbg_ra (0 for r0)
- pc  out  32  current program counter
- instr  out  32  instruction register
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  sticky; set on illegal instruction or misaligned data address

## Operation
- Supported: R-type (op 0) add/sub/and/or/slt (funct 20/22/24/25/2A hex), lw (23), sw (2B), addi (08), beq (04), j (02). Any other op/funct is illegal.
- Register file: 32 x 32, two read ports plus dbg port, one write port; r0 reads 0, writes to r0 discarded.
- Arithmetic mod 2^32, no overflow traps; slt signed; immediate sign-extended 16->32.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold until mem_ready; then instr<=mem_rdata, pc<=pc+4 -> DECODE.
  - DECODE: latch A=R[rs], B=R[rt]; ALUOut<=pc+(SignImm<<2); illegal -> HALT; lw/sw -> MEMADR; R-type -> EXEC; addi -> ADDIEX; beq -> BRANCH; j -> JUMP.
  - MEMADR: ALUOut<=A+SignImm; if ALUOut[1:0]!=0 -> HALT; lw -> MEMRD; sw -> MEMWR.
  - MEMRD: read at ALUOut, wait for mem_ready, data register<=mem_rdata -> MEMWB.
  - MEMWB: R[rt]<=data register, retire -> FETCH.
  - MEMWR: write B to ALUOut, wait for mem_ready, retire -> FETCH.
  - EXEC: ALUOut<=A op B -> ALUWB; ALUWB: R[rd]<=ALUOut, retire -> FETCH.
  - ADDIEX: ALUOut<=A+SignImm -> ADDIWB; ADDIWB: R[rt]<=ALUOut, retire -> FETCH.
  - BRANCH: if A==B pc<=ALUOut; retire -> FETCH.
  - JUMP: pc<={pc[31:28], instr[25:0], 2'b00}; retire -> FETCH.
  - HALT: terminal until reset; halted=1, mem_req=0, no further register/pc changes.
- mem_req/mem_we/mem_addr/mem_wdata are stable from assertion until the edge mem_ready is sampled high.

## Timing
- Reset values: pc=RESET_PC, instr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halted=0, all registers 0, state=FETCH. First mem_req on the first edge after reset deasserts (mem_req is a registered output).
- Zero-wait-state cycles per instruction: beq/j 3, R-type/addi/sw 4, lw 5. Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds one cycle.
- retire is high for exactly one cycle, in the final state of each instruction; never in HALT.
- mem_ready while mem_req=0 has no effect.
- Reset mid-transaction: all outputs go to reset values immediately (asynchronously); a pending write is abandoned.
- Registers written in a writeback state are visible on the next DECODE and on dbg_rd the following cycle.
- Back-to-back instructions: FETCH begins the cycle after the retiring state.

## Test plan
- Reset: RESET_PC=32'h100, hold reset 3 cycles -> all outputs at reset values; first fetch addr 32'h100.
- ALU sequence: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1; sub r5,r2,r1 -> dbg r3=2, r4=1, r5=32'hFFFFFFF8; each R-type retires 4 cycles after previous retire.
- Memory with wait states: sw r1,8(r0) then lw r6,8(r0), mem_ready held low 2 cycles per transaction -> write addr 8 data 5; r6=5; lw takes 5+4 cycles.
- Control flow: beq r1,r1,+2 at pc 0x10 -> next fetch 0x1C; beq not taken -> 0x14; j 0x40 -> fetch 0x100.
- Faults: opcode 0x3F -> halted=1 after DECODE, mem_req stays 0; lw r1,2(r0) -> halted, no read issued; addi r0,r0,7 -> dbg r0=0.
- Reset asserted during a stalled sw (mem_req=1, mem_ready=0) -> mem_req=0 same cycle, pc=RESET_PC, no write recorded.
